reg_lock_tracker: RTL and testbench
===================================

REG_LOCK_TRACKER -- requirements
Module: reg_lock_tracker

Interface
REQ-001 SHALL have parameter NUM_REGS, default maverickOne_pkg::NUM_REGS, meaning the number of architectural registers tracked.
REQ-002 SHALL have parameter CNT_W, default maverickOne_pkg::REG_LOCK_CNT_W (2), meaning the width of each per-register outstanding-write counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port arst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous flush of all locks.
REQ-006 SHALL have port lock_valid_i, input, 1 bit: the launcher is issuing an instruction that writes lock_rd_i.
REQ-007 SHALL have port lock_rd_i, input, $clog2(NUM_REGS) bits: destination register to lock.
REQ-008 SHALL have port lock_ready_o, output, 1 bit: the lock can be accepted this cycle.
REQ-009 SHALL have port release_valid_i, input, 1 bit: a writeback has completed for release_rd_i.
REQ-010 SHALL have port release_rd_i, input, $clog2(NUM_REGS) bits: register to release.
REQ-011 SHALL have port locks_o, output, NUM_REGS bits: per-register lock profile, feeding instr_launcher locks_i.
REQ-012 SHALL have port err_o, output, 1 bit: sticky release-underflow flag; present only with REG_LOCK_ERR_EN.

Function
REQ-013 SHALL hold one CNT_W-bit counter cnt[r] per register; locks_o[r] = (cnt[r] != 0), combinational from the counters.
REQ-014 SHALL treat register 0 as never locked: locks_o[0]=0, cnt[0] stays 0, and lock or release of r0 is a no-op with lock_ready_o=1.
REQ-015 SHALL define lock fire = lock_valid_i & lock_ready_o; on fire, cnt[lock_rd_i] increments at the next edge.
REQ-016 SHALL drive lock_ready_o=0 only when cnt[lock_rd_i] == 2^CNT_W-1 and no same-cycle release of the same register is present; otherwise 1.
REQ-017 SHALL, on release_valid_i with cnt[release_rd_i] != 0, decrement that counter at the next edge.
REQ-018 SHALL ignore a release to a register whose count is 0: no wrap-around, count stays 0.
REQ-019 SHALL leave the count unchanged for a simultaneous lock fire and release to the same register, including at saturation.
REQ-020 SHALL apply a simultaneous lock fire and release to different registers independently in the same cycle.
REQ-021 SHALL give locks_o a latency of 1 cycle: a lock or release is visible on the cycle after its handshake edge.
REQ-022 SHALL, when clear_i=1, zero all counters at the next edge; clear dominates any same-cycle lock or release.

Reset
REQ-023 SHALL, while arst_i=1, immediately force all counters to 0, locks_o='0, lock_ready_o=1 and err_o=0, independent of clk_i.
REQ-024 SHALL discard any handshake in flight when reset is asserted mid-operation; operation resumes at the first edge after deassertion.

Configuration
REQ-025 SHALL compile the err_o port and its sticky logic only when REG_LOCK_ERR_EN is defined; err_o sets on a release to a zero-count non-zero register (REQ-018) and clears only on arst_i or clear_i.
REQ-026 SHALL, without REG_LOCK_ERR_EN, omit err_o entirely and keep the ignore behaviour of REQ-018 unchanged.

Structure
REQ-027 SHALL take NUM_REGS and REG_LOCK_CNT_W from maverickOne_pkg; REG_LOCK_CNT_W SHALL be added there.
REQ-028 SHALL instantiate the counter for each register r = 1..NUM_REGS-1 as sub-module reg_lock_cnt, which has inc, dec, clear, count and full ports.

Verification
REQ-029 Verification: lock r5 with counter at 0 -> the next cycle locks_o[5]=1; release r5 -> the cycle after, locks_o[5]=0.
REQ-030 Verification: with CNT_W=2, lock r7 three times -> lock_ready_o=0 while lock_rd_i=7; add a same-cycle release of r7 -> lock_ready_o=1 and the count stays 3.
REQ-031 Verification: lock r0 and release r0 -> locks_o[0] stays 0 and lock_ready_o stays 1.
REQ-032 Verification: release r9 at count 0 -> count stays 0; with REG_LOCK_ERR_EN, err_o=1 next cycle and stays 1 until clear_i.
REQ-033 Verification: registers 3 and 4 locked, then clear_i=1 with a same-cycle lock of r3 -> locks_o='0 next cycle.
REQ-034 Verification: assert arst_i mid-stream with multiple registers locked -> locks_o='0 and lock_ready_o=1 without a clock edge.

Source files
------------

// File: rtl/maverickOne_pkg.sv
// Shared core parameters and types used by the register lock tracker.
package maverickOne_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned REG_LOCK_CNT_W = 2;

  typedef enum logic [1:0] {
    CntHold,
    CntInc,
    CntDec,
    CntClear
  } cnt_op_e;

endpackage

// File: rtl/reg_lock_cnt.sv
// Saturating outstanding-write counter for one architectural register.
module reg_lock_cnt
  import maverickOne_pkg::*;
#(
  parameter int unsigned CNT_W = REG_LOCK_CNT_W
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [CNT_W-1:0] count_q, count_d;
  cnt_op_e          op;

  assign count_o = count_q;
  assign full_o  = (count_q == '1);

  // A same-cycle inc and dec cancel; a dec at zero is dropped rather than wrapping.
  always_comb begin
    op = CntHold;
    if (clear_i) begin
      op = CntClear;
    end else if (inc_i && !dec_i && !full_o) begin
      op = CntInc;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      op = CntDec;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case (op)
      CntInc:   count_d = count_q + CNT_W'(1);
      CntDec:   count_d = count_q - CNT_W'(1);
      CntClear: count_d = '0;
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg_lock_tracker.sv
// Per-register outstanding-write scoreboard feeding the instruction launcher.
// Optional sticky underflow flag err_o is built when REG_LOCK_ERR_EN is defined.
module reg_lock_tracker #(
  parameter int unsigned NUM_REGS = maverickOne_pkg::NUM_REGS,
  parameter int unsigned CNT_W    = maverickOne_pkg::REG_LOCK_CNT_W
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic                        clear_i,
  input  logic                        lock_valid_i,
  input  logic [$clog2(NUM_REGS)-1:0] lock_rd_i,
  output logic                        lock_ready_o,
  input  logic                        release_valid_i,
  input  logic [$clog2(NUM_REGS)-1:0] release_rd_i,
  output logic [NUM_REGS-1:0]         locks_o
`ifdef REG_LOCK_ERR_EN
  ,
  output logic                        err_o
`endif
);

  localparam int unsigned RdW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] full;
  logic                same_reg;
  logic                lock_fire;

  // A release of the same register frees a slot, so a full counter may still accept.
  assign same_reg     = release_valid_i && (release_rd_i == lock_rd_i);
  assign lock_ready_o = !(full[lock_rd_i] && !same_reg);
  assign lock_fire    = lock_valid_i && lock_ready_o;

  // r0 is hardwired zero and never needs tracking.
  assign full[0]    = 1'b0;
  assign locks_o[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic [CNT_W-1:0] count;
    logic             inc;
    logic             dec;

    assign inc = lock_fire && (lock_rd_i == RdW'(r));
    assign dec = release_valid_i && (release_rd_i == RdW'(r));

    reg_lock_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .clear_i(clear_i),
      .inc_i  (inc),
      .dec_i  (dec),
      .count_o(count),
      .full_o (full[r])
    );

    assign locks_o[r] = (count != '0);
  end

`ifdef REG_LOCK_ERR_EN
  logic err_q, err_d;
  logic underflow;

  assign underflow = release_valid_i && (release_rd_i != '0) && !locks_o[release_rd_i];

  always_comb begin
    err_d = err_q | underflow;
    if (clear_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Scoreboard bench for reg_lock_tracker: directed scenarios then random traffic.
module tb_reg_lock_tracker;

  localparam int NR  = 32;
  localparam int RW  = 5;
  localparam int MAX = 3;

  typedef struct packed {
    logic [NR-1:0] locks;
    logic          ready;
    logic          err;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          clear_i;
  logic          lock_valid_i;
  logic [RW-1:0] lock_rd_i;
  logic          lock_ready_o;
  logic          release_valid_i;
  logic [RW-1:0] release_rd_i;
  logic [NR-1:0] locks_o;
`ifdef REG_LOCK_ERR_EN
  logic          err_o;
`endif

  reg_lock_tracker #(
    .NUM_REGS(NR),
    .CNT_W   (2)
  ) dut (
    .clk_i          (clk_i),
    .arst_i         (arst_i),
    .clear_i        (clear_i),
    .lock_valid_i   (lock_valid_i),
    .lock_rd_i      (lock_rd_i),
    .lock_ready_o   (lock_ready_o),
    .release_valid_i(release_valid_i),
    .release_rd_i   (release_rd_i),
    .locks_o        (locks_o)
`ifdef REG_LOCK_ERR_EN
    ,
    .err_o          (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference: outstanding-write count per register plus the sticky error bit.
  int   m_cnt[NR];
  logic m_err;

  function automatic logic [NR-1:0] model_locks();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic a, input logic c, input logic lv, input int lrd,
                      input logic rv, input int rrd);
    exp_t e;
    logic rdy;
    @(posedge clk_i);
    #1;
    arst_i          = a;
    clear_i         = c;
    lock_valid_i    = lv;
    lock_rd_i       = lrd[RW-1:0];
    release_valid_i = rv;
    release_rd_i    = rrd[RW-1:0];
    if (a) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_err = 1'b0;
    end
    rdy     = !(m_cnt[lrd] == MAX && !(rv && rrd == lrd));
    e.ready = rdy;
    e.locks = model_locks();
    e.err   = m_err;
    sb_q.push_back(e);
    if (!a) begin
      if (c) begin
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_err = 1'b0;
      end else begin
        logic fire, rel;
        fire = lv && rdy && (lrd != 0);
        rel  = rv && (rrd != 0);
        if (rel && m_cnt[rrd] == 0) m_err = 1'b1;
        if (!(fire && rel && lrd == rrd)) begin
          if (fire) m_cnt[lrd] = m_cnt[lrd] + 1;
          if (rel && m_cnt[rrd] > 0) m_cnt[rrd] = m_cnt[rrd] - 1;
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  function automatic int pick_reg();
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0: return 0;
      1: return 3;
      2: return 5;
      3: return 7;
      default: return $urandom_range(0, NR - 1);
    endcase
  endfunction

  // Monitor: outputs are combinational every cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("locks_o", int'(locks_o), int'(e.locks));
        check("lock_ready_o", int'(lock_ready_o), int'(e.ready));
`ifdef REG_LOCK_ERR_EN
        check("err_o", int'(err_o), int'(e.err));
`endif
      end
    end
  end

  initial begin
    int guard;
    arst_i = 1'b1; clear_i = 1'b0; lock_valid_i = 1'b0; lock_rd_i = '0;
    release_valid_i = 1'b0; release_rd_i = '0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_err = 1'b0;

    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 5, 1'b0, 0);
    idle();
    // Lock and release r5.
    step(1'b0, 1'b0, 1'b1, 5, 1'b0, 0);
    idle();
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 5);
    idle();
    // Saturate r7, then probe ready with and without a same-register release.
    repeat (3) step(1'b0, 1'b0, 1'b1, 7, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 7, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 7, 1'b1, 7);
    step(1'b0, 1'b0, 1'b1, 7, 1'b0, 0);
    // r0 is never locked.
    step(1'b0, 1'b0, 1'b1, 0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 0);
    // Underflow on r9, sticky until clear.
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 9);
    idle();
    idle();
    step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0);
    idle();
    // Clear dominates a same-cycle lock.
    step(1'b0, 1'b0, 1'b1, 3, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 4, 1'b1, 9);
    step(1'b0, 1'b1, 1'b1, 3, 1'b1, 4);
    idle();
    // Asynchronous reset with several registers held.
    step(1'b0, 1'b0, 1'b1, 5, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 7, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 6, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 8, 1'b1, 5);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    idle();

    for (int n = 0; n < 600; n++) begin
      logic a, c;
      a = ($urandom_range(0, 149) == 0);
      c = ($urandom_range(0, 49) == 0);
      step(a, c, 1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 2) == 0), pick_reg());
    end
    idle();

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk_i);
      guard++;
    end
    @(posedge clk_i);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
